// File: rtl/rr_muxnv.sv
// rtl/rr_muxnv.sv - registered N-channel round-robin mux with valid/ready on every port
// Optional packet lock enabled by defining RR_MUX_LOCK_EN.
module rr_muxnv #(
    parameter int width    = 32,
    parameter int channels = 4,
    parameter bit rr       = 1'b1,
    localparam int sw      = (channels > 1) ? $clog2(channels) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [channels*width-1:0] in_data,
    input  logic [channels-1:0]       in_valid,
    input  logic [channels-1:0]       in_last,
    output logic [channels-1:0]       in_ready,
    output logic [width-1:0]          out_data,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [sw-1:0]             out_sel,
    input  logic                      out_ready
);

    logic             load;
    logic [sw-1:0]    ptr;
    logic             gnt_found;
    logic [sw-1:0]    gnt_idx;
    logic [sw:0]      cand;
    logic [width-1:0] sel_data;
    logic             sel_last;
    logic [sw-1:0]    ptr_next;

`ifdef RR_MUX_LOCK_EN
    logic             lock;
    logic [sw-1:0]    lock_ch;
`endif

    assign load = ~out_valid | out_ready;

    // Search upward from ptr with wraparound; fixed-priority mode keeps ptr at 0.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int j = 0; j < channels; j++) begin
            cand = {1'b0, ptr} + (sw+1)'(j);
            if (cand >= (sw+1)'(channels)) begin
                cand = cand - (sw+1)'(channels);
            end
            if (!gnt_found && in_valid[cand[sw-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[sw-1:0];
            end
        end
`ifdef RR_MUX_LOCK_EN
        if (lock) begin
            gnt_found = in_valid[lock_ch];
            gnt_idx   = lock_ch;
        end
`endif
    end

    always_comb begin
        in_ready = '0;
        if (reset_n && load && gnt_found) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < channels; i++) begin
            if (gnt_idx == sw'(i)) begin
                sel_data = in_data[i*width +: width];
            end
        end
        sel_last = in_last[gnt_idx];
    end

    assign ptr_next = (gnt_idx == sw'(channels - 1)) ? '0 : gnt_idx + sw'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_sel   <= '0;
            ptr       <= '0;
`ifdef RR_MUX_LOCK_EN
            lock      <= 1'b0;
            lock_ch   <= '0;
`endif
        end else if (load) begin
            if (gnt_found) begin
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_sel   <= gnt_idx;
                out_valid <= 1'b1;
`ifdef RR_MUX_LOCK_EN
                // Mid-packet beats pin the grant; ptr only moves once the packet ends.
                if (!sel_last) begin
                    lock    <= 1'b1;
                    lock_ch <= gnt_idx;
                end else begin
                    lock <= 1'b0;
                    if (rr) begin
                        ptr <= ptr_next;
                    end
                end
`else
                if (rr) begin
                    ptr <= ptr_next;
                end
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
